// File: rtl/event_reader_pkg.sv
// Shared definitions for the timestamp-channel readout engine:
// FSM encodings, record header layout and settle timing.
package event_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEND   = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    localparam int HDR_SYNC      = 7;
    localparam int HDR_OVR       = 6;
    localparam int SETTLE_CYCLES = 2;
    localparam int REC_LEN       = 9;

    function automatic logic [7:0] make_hdr(input logic ovr, input logic [2:0] ch);
        logic [7:0] h;
        h           = '0;
        h[HDR_SYNC] = 1'b1;
        h[HDR_OVR]  = ovr;
        h[2:0]      = ch;
        return h;
    endfunction

endpackage

// File: rtl/event_reader_rr_pick.sv
// Combinational round-robin priority encoder: first request at or after
// i_ptr, wrapping modulo NCHAN.
module rr_pick #(
    parameter int NCHAN = 4
) (
    input  logic [NCHAN-1:0] i_req,
    input  logic [2:0]       i_ptr,
    output logic             o_hit,
    output logic [2:0]       o_idx
);

    logic [7:0] w_req;
    logic [3:0] w_pos;

    always_comb begin
        w_req            = '0;
        w_req[NCHAN-1:0] = i_req;
        w_pos            = '0;
        o_hit            = 1'b0;
        o_idx            = '0;
        // walk from the farthest slot back toward i_ptr so the nearest request wins
        for (int i = NCHAN - 1; i >= 0; i--) begin
            w_pos = {1'b0, i_ptr} + 4'(i);
            if (w_pos >= 4'(NCHAN)) begin
                w_pos = w_pos - 4'(NCHAN);
            end
            if (w_req[w_pos[2:0]]) begin
                o_hit = 1'b1;
                o_idx = w_pos[2:0];
            end
        end
    end

endmodule

// File: rtl/event_reader.sv
// Round-robin readout of timestamp channels into header+8-byte (or overrun-only)
// records on a valid/ready byte stream; all outputs registered.
module event_reader
    import event_reader_pkg::*;
#(
    parameter int NCHAN = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NCHAN-1:0]   attention,
    input  logic [NCHAN-1:0]   overrun,
    input  logic [8*NCHAN-1:0] chdata,
    output logic [2:0]         byteaddr,
    output logic [NCHAN-1:0]   unload,
    output logic [NCHAN-1:0]   clearoverrun,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy
);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_ch, w_ch_nxt;
    logic             r_ovr, w_ovr_nxt;
    logic [2:0]       r_rr_ptr, w_rr_nxt;
    logic [1:0]       r_settle, w_settle_nxt;
    logic [2:0]       r_byteaddr, w_addr_nxt;
    logic [7:0]       r_tx_data, w_data_nxt;
    logic             r_tx_valid, w_valid_nxt;
    logic [NCHAN-1:0] r_unload, w_unload_nxt;
    logic [NCHAN-1:0] r_clrovr, w_clrovr_nxt;
    logic             r_busy;

    logic             w_hit;
    logic [2:0]       w_pick_idx;
    logic [NCHAN-1:0] w_pick_oh;
    logic [NCHAN-1:0] w_ch_oh;
    logic [7:0]       w_byte;
    logic             w_hs;

    rr_pick #(.NCHAN(NCHAN)) u_rr_pick (
        .i_req (attention),
        .i_ptr (r_rr_ptr),
        .o_hit (w_hit),
        .o_idx (w_pick_idx)
    );

    always_comb begin
        w_ch_oh   = '0;
        w_pick_oh = '0;
        w_byte    = '0;
        for (int k = 0; k < NCHAN; k++) begin
            w_ch_oh[k]   = (r_ch == 3'(k));
            w_pick_oh[k] = (w_pick_idx == 3'(k));
            if (r_ch == 3'(k)) begin
                w_byte = chdata[8*k +: 8];
            end
        end
    end

    assign w_hs = r_tx_valid && tx_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_ch_nxt     = r_ch;
        w_ovr_nxt    = r_ovr;
        w_rr_nxt     = r_rr_ptr;
        w_settle_nxt = r_settle;
        w_addr_nxt   = r_byteaddr;
        w_data_nxt   = r_tx_data;
        w_valid_nxt  = r_tx_valid;
        w_unload_nxt = '0;
        w_clrovr_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    w_ch_nxt    = w_pick_idx;
                    w_ovr_nxt   = |(overrun & w_pick_oh);
                    w_data_nxt  = make_hdr(|(overrun & w_pick_oh), w_pick_idx);
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (r_ovr) begin
                        w_clrovr_nxt = w_ch_oh;
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        w_addr_nxt  = 3'd7;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                w_data_nxt  = w_byte;
                w_valid_nxt = 1'b1;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (r_byteaddr == 3'd0) begin
                        w_unload_nxt = w_ch_oh;
                        w_settle_nxt = '0;
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        w_addr_nxt  = r_byteaddr - 3'd1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_SETTLE: begin
                // the channels' attention lags a pop/clear, so hold off rescanning
                if (r_settle == 2'(SETTLE_CYCLES - 1)) begin
                    w_rr_nxt    = (r_ch == 3'(NCHAN - 1)) ? 3'd0 : r_ch + 3'd1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_settle_nxt = r_settle + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_ch       <= '0;
            r_ovr      <= 1'b0;
            r_rr_ptr   <= '0;
            r_settle   <= '0;
            r_byteaddr <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_unload   <= '0;
            r_clrovr   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch       <= w_ch_nxt;
            r_ovr      <= w_ovr_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_settle   <= w_settle_nxt;
            r_byteaddr <= w_addr_nxt;
            r_tx_data  <= w_data_nxt;
            r_tx_valid <= w_valid_nxt;
            r_unload   <= w_unload_nxt;
            r_clrovr   <= w_clrovr_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign byteaddr     = r_byteaddr;
    assign unload       = r_unload;
    assign clearoverrun = r_clrovr;
    assign tx_data      = r_tx_data;
    assign tx_valid     = r_tx_valid;
    assign busy         = r_busy;

endmodule

// File: tb/tb_event_reader.sv
// Directed bench for event_reader: behavioural channel model plus a byte
// scoreboard filled when events are queued and drained on each handshake.
module tb_event_reader;

    localparam int NCHAN = 4;

    typedef struct {
        logic [7:0] b;
        int         kind;   // 0 plain byte, 1 last data byte, 2 overrun header
        int         ch;
    } exp_t;

    logic               clk = 1'b0;
    logic               rstn;
    logic [NCHAN-1:0]   attention;
    logic [NCHAN-1:0]   overrun;
    logic [8*NCHAN-1:0] chdata;
    logic [2:0]         byteaddr;
    logic [NCHAN-1:0]   unload;
    logic [NCHAN-1:0]   clearoverrun;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;

    logic [63:0]      fifo [NCHAN][$];
    logic [NCHAN-1:0] ovr;
    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    int               hs_cnt   = 0;
    int               rdy_mode = 0;
    int               unl_cnt [NCHAN];
    logic [NCHAN-1:0] exp_unl_nxt, exp_clr_nxt, p_unload, p_clr;
    logic             p_valid, p_ready;
    logic [7:0]       p_data;

    event_reader #(.NCHAN(NCHAN)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .attention    (attention),
        .overrun      (overrun),
        .chdata       (chdata),
        .byteaddr     (byteaddr),
        .unload       (unload),
        .clearoverrun (clearoverrun),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input int ch, input logic [63:0] w);
        exp_t e;
        e.b    = 8'h80 | 8'(ch);
        e.kind = 0;
        e.ch   = ch;
        sb.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            e.b    = w[8*i +: 8];
            e.kind = (i == 0) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic push_ovr(input int ch);
        exp_t e;
        e.b    = 8'hC0 | 8'(ch);
        e.kind = 2;
        e.ch   = ch;
        sb.push_back(e);
    endtask

    // One clock: update the channel model from last cycle's strobes, drive inputs, check outputs.
    task automatic step();
        logic [NCHAN-1:0] flags, exp_unl, exp_clr;
        logic [63:0]      w;
        exp_t             e;
        @(posedge clk);
        #1;
        for (int k = 0; k < NCHAN; k++) flags[k] = (fifo[k].size() != 0) || ovr[k];
        for (int k = 0; k < NCHAN; k++) begin
            if (p_unload[k] && fifo[k].size() != 0) void'(fifo[k].pop_front());
            if (p_clr[k]) ovr[k] = 1'b0;
        end
        attention = flags;
        overrun   = ovr;
        for (int k = 0; k < NCHAN; k++) begin
            w = (fifo[k].size() != 0) ? fifo[k][0] : 64'h0;
            chdata[8*k +: 8] = 8'(w >> (8 * int'(byteaddr)));
        end
        tx_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);

        exp_unl     = exp_unl_nxt;
        exp_clr     = exp_clr_nxt;
        exp_unl_nxt = '0;
        exp_clr_nxt = '0;
        chk("unload", 64'(unload), 64'(exp_unl));
        chk("clearoverrun", 64'(clearoverrun), 64'(exp_clr));
        if (p_valid && !p_ready) begin
            chk("stall_valid", 64'(tx_valid), 64'd1);
            chk("stall_data", 64'(tx_data), 64'(p_data));
        end
        if (tx_valid && tx_ready) begin
            hs_cnt++;
            chk("byte_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("tx_byte", 64'(tx_data), 64'(e.b));
                if (e.kind == 1) exp_unl_nxt[e.ch] = 1'b1;
                if (e.kind == 2) exp_clr_nxt[e.ch] = 1'b1;
            end
        end
        for (int k = 0; k < NCHAN; k++) unl_cnt[k] += int'(unload[k]);
        p_unload = unload;
        p_clr    = clearoverrun;
        p_valid  = tx_valid;
        p_ready  = tx_ready;
        p_data   = tx_data;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        for (int k = 0; k < NCHAN; k++) begin
            fifo[k].delete();
            unl_cnt[k] = 0;
        end
        ovr         = '0;
        sb.delete();
        exp_unl_nxt = '0;
        exp_clr_nxt = '0;
        p_unload    = '0;
        p_clr       = '0;
        p_valid     = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag, input int limit);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < limit) begin
            step();
            n++;
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        for (int k = 0; k < NCHAN; k++) chk({tag, "_fifo_empty"}, 64'(fifo[k].size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_byteaddr"}, 64'(byteaddr), 64'd0);
        chk({tag, "_unload"}, 64'(unload), 64'd0);
        chk({tag, "_clearoverrun"}, 64'(clearoverrun), 64'd0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] w0, w1, w2, w3;
        int          span, vcnt, n;

        rstn        = 1'b0;
        tx_ready    = 1'b0;
        attention   = '0;
        overrun     = '0;
        chdata      = '0;
        ovr         = '0;
        exp_unl_nxt = '0;
        exp_clr_nxt = '0;
        p_unload    = '0;
        p_clr       = '0;
        p_valid     = 1'b0;
        p_ready     = 1'b0;
        p_data      = '0;
        for (int k = 0; k < NCHAN; k++) unl_cnt[k] = 0;
        #1;
        chk_zero_outputs("reset");
        do_reset();

        // Single event on ch2: span counted from the IDLE hit cycle to the return to IDLE
        fifo[2].push_back(64'h02468ACF_13579BDD);
        push_rec(2, 64'h02468ACF_13579BDD);
        step();
        chk("single_hit_busy", 64'(busy), 64'd0);
        span = 0;
        vcnt = 0;
        do begin
            step();
            span++;
            if (tx_valid) vcnt++;
        end while (busy !== 1'b0 && span < 100);
        chk("single_record_clks", 64'(span), 64'd20);
        chk("single_valid_clks", 64'(vcnt), 64'd9);
        chk("single_unload_cnt", 64'(unl_cnt[2]), 64'd1);
        drain("single", 50);

        // Round-robin between ch0 and ch3, two events each
        do_reset();
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        w3 = {$urandom, $urandom};
        fifo[0].push_back(w0);
        fifo[0].push_back(w1);
        fifo[3].push_back(w2);
        fifo[3].push_back(w3);
        push_rec(0, w0);
        push_rec(3, w2);
        push_rec(0, w1);
        push_rec(3, w3);
        drain("rr", 300);
        chk("rr_unload_ch0", 64'(unl_cnt[0]), 64'd2);
        chk("rr_unload_ch3", 64'(unl_cnt[3]), 64'd2);

        // Overrun on ch1 with a word queued: overrun header first, data on the next visit
        do_reset();
        w0 = {$urandom, $urandom};
        ovr[1] = 1'b1;
        fifo[1].push_back(w0);
        push_ovr(1);
        push_rec(1, w0);
        drain("ovr", 200);
        chk("ovr_flag_cleared", 64'(ovr[1]), 64'd0);
        chk("ovr_unload_ch1", 64'(unl_cnt[1]), 64'd1);

        // Backpressure: tx_ready randomly high about one clk in four
        do_reset();
        rdy_mode = 1;
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        w2 = {$urandom, $urandom};
        fifo[1].push_back(w0);
        fifo[1].push_back(w1);
        fifo[2].push_back(w2);
        push_rec(1, w0);
        push_rec(2, w2);
        push_rec(1, w1);
        drain("bp", 3000);
        rdy_mode = 0;
        chk("bp_unload_ch1", 64'(unl_cnt[1]), 64'd2);
        chk("bp_unload_ch2", 64'(unl_cnt[2]), 64'd1);

        // Reset after the fourth byte: word must be retained and resent in full
        do_reset();
        w0 = {$urandom, $urandom};
        fifo[2].push_back(w0);
        push_rec(2, w0);
        hs_cnt = 0;
        n = 0;
        while (hs_cnt < 4 && n < 100) begin
            step();
            n++;
        end
        chk("midrst_bytes_sent", 64'(hs_cnt), 64'd4);
        step();
        rstn = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        sb.delete();
        exp_unl_nxt = '0;
        exp_clr_nxt = '0;
        p_valid     = 1'b0;
        for (int i = 0; i < 3; i++) step();
        rstn = 1'b1;
        chk("midrst_word_kept", 64'(fifo[2].size()), 64'd1);
        chk("midrst_no_unload", 64'(unl_cnt[2]), 64'd0);
        push_rec(2, w0);
        drain("midrst_resend", 100);
        chk("midrst_unload_cnt", 64'(unl_cnt[2]), 64'd1);

        // Empty system: nothing requesting for 100 clks
        do_reset();
        for (int i = 0; i < 100; i++) begin
            step();
            chk("empty_tx_valid", 64'(tx_valid), 64'd0);
            chk("empty_busy", 64'(busy), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
